// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared USB receive-path types and default constants
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PID,
    COUNT,
    DROP,
    ERROR
  } unstuff_state_t;

  localparam int DEFAULT_STUFF_RUN = 6;
  localparam int DEFAULT_PID_BITS  = 8;

endpackage

// File: rtl/bu_run_counter.sv
// rtl/bu_run_counter.sv - consecutive-ones run counter with terminal flag at STUFF_RUN-1
module bu_run_counter #(
  parameter int STUFF_RUN = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);

  localparam logic [2:0] TERM_CNT = 3'(STUFF_RUN - 1);

  logic [2:0] ones_cnt_q;
  logic [2:0] ones_cnt_d;

  always_comb begin
    ones_cnt_d = ones_cnt_q;
    if (clr_i) begin
      ones_cnt_d = 3'd0;
    end else if (inc_i) begin
      ones_cnt_d = ones_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ones_cnt_q <= 3'd0;
    end else begin
      ones_cnt_q <= ones_cnt_d;
    end
  end

  assign term_o = (ones_cnt_q == TERM_CNT);

endmodule

// File: rtl/bit_unstuffer.sv
// rtl/bit_unstuffer.sv - receive bit unstuffer; BIT_UNSTUFF_STATS_EN adds drop_cnt
module bit_unstuffer
  import usb_rx_pkg::*;
#(
  parameter int PID_BITS  = DEFAULT_PID_BITS,
  parameter int STUFF_RUN = DEFAULT_STUFF_RUN
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic        rx_bit,
  output logic        out_valid,
  output logic        out_bit,
  output logic        stuff_err,
  output logic        bu_busy
`ifdef BIT_UNSTUFF_STATS_EN
  ,output logic [15:0] drop_cnt
`endif
);

  localparam int BCW = $clog2(PID_BITS + 1);
  localparam logic [BCW-1:0] PID_LAST = BCW'(PID_BITS - 1);

  unstuff_state_t state_q, state_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic           out_valid_q, out_bit_q, stuff_err_q;
  logic           prev_valid_q;

  logic pass, err, drop, pkt_start;
  logic cnt_clr, cnt_inc, cnt_term;

  bu_run_counter #(
    .STUFF_RUN(STUFF_RUN)
  ) u_run_counter (
    .clock  (clock),
    .reset_n(reset_n),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .term_o (cnt_term)
  );

  // A packet may only start after rx_valid has been seen low, so a reset
  // landing mid-packet suppresses the rest of that packet.
  assign pkt_start = (state_q == IDLE) && rx_valid && !prev_valid_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    pass      = 1'b0;
    err       = 1'b0;
    drop      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pkt_start) begin
          pass      = 1'b1;
          bit_cnt_d = BCW'(1);
          cnt_clr   = 1'b1;
          state_d   = (PID_BITS > 1) ? PID : COUNT;
        end
      end
      PID: begin
        if (rx_valid) begin
          pass      = 1'b1;
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == PID_LAST) begin
            cnt_clr = 1'b1;
            state_d = COUNT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      COUNT: begin
        if (rx_valid) begin
          pass = 1'b1;
          if (!rx_bit) begin
            cnt_clr = 1'b1;
          end else if (cnt_term) begin
            cnt_clr = 1'b1;
            state_d = DROP;
          end else begin
            cnt_inc = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DROP: begin
        // The transmitter always emits the stuffed 0, so a missing one is an error.
        if (rx_valid && !rx_bit) begin
          drop    = 1'b1;
          cnt_clr = 1'b1;
          state_d = COUNT;
        end else begin
          err     = 1'b1;
          state_d = rx_valid ? ERROR : IDLE;
        end
      end
      ERROR: begin
        if (!rx_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      out_valid_q  <= 1'b0;
      out_bit_q    <= 1'b0;
      stuff_err_q  <= 1'b0;
      prev_valid_q <= rx_valid;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      out_valid_q  <= pass;
      out_bit_q    <= pass & rx_bit;
      stuff_err_q  <= err;
      prev_valid_q <= rx_valid;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign stuff_err = stuff_err_q;
  assign bu_busy   = (state_q != IDLE);

`ifdef BIT_UNSTUFF_STATS_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      drop_cnt_q <= 16'd0;
    end else if (pkt_start) begin
      drop_cnt_q <= 16'd0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_bit_unstuffer.sv
// tb/tb_bit_unstuffer.sv - scoreboard bench for bit_unstuffer
module tb_bit_unstuffer;

  localparam int PID_BITS  = 8;
  localparam int STUFF_RUN = 6;

  logic clock = 1'b0;
  logic reset_n;
  logic rx_valid;
  logic rx_bit;
  logic out_valid;
  logic out_bit;
  logic stuff_err;
  logic bu_busy;
`ifdef BIT_UNSTUFF_STATS_EN
  logic [15:0] drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic v;
    logic b;
    logic e;
    logic busy;
  } exp_t;

  exp_t exp_q[$];

  always #5 clock = ~clock;

  bit_unstuffer #(
    .PID_BITS (PID_BITS),
    .STUFF_RUN(STUFF_RUN)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .rx_valid (rx_valid),
    .rx_bit   (rx_bit),
    .out_valid(out_valid),
    .out_bit  (out_bit),
    .stuff_err(stuff_err),
    .bu_busy  (bu_busy)
`ifdef BIT_UNSTUFF_STATS_EN
    ,.drop_cnt(drop_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_eq("out_valid", {31'd0, out_valid}, {31'd0, e.v});
      if (e.v) check_eq("out_bit", {31'd0, out_bit}, {31'd0, e.b});
      check_eq("stuff_err", {31'd0, stuff_err}, {31'd0, e.e});
      check_eq("bu_busy", {31'd0, bu_busy}, {31'd0, e.busy});
    end
  end

  task automatic step(input logic v, input logic b, input logic rn, input exp_t e);
    rx_valid = v;
    rx_bit   = b;
    reset_n  = rn;
    @(posedge clock);
    exp_q.push_back(e);
    #1;
  endtask

  // Bits are sent MSB first; rst_at < 0 means no reset inside the packet.
  task automatic send_packet(input logic [63:0] bits, input int n, input int rst_at);
    int   ones     = 0;
    int   drops    = 0;
    logic pending  = 1'b0;
    logic errored  = 1'b0;
    logic aborted  = 1'b0;
    logic b;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      b = bits[n-1-i];
      e = '{v: 1'b0, b: 1'b0, e: 1'b0, busy: 1'b1};
      if (i == rst_at) begin
        aborted = 1'b1;
        drops   = 0;
      end
      if (aborted) begin
        e.busy = 1'b0;
      end else if (i < PID_BITS) begin
        e.v = 1'b1;
        e.b = b;
      end else if (errored) begin
        e.v = 1'b0;
      end else if (pending) begin
        pending = 1'b0;
        if (b) begin
          e.e     = 1'b1;
          errored = 1'b1;
        end else begin
          drops++;
        end
        ones = 0;
      end else begin
        e.v = 1'b1;
        e.b = b;
        if (b) begin
          ones++;
          if (ones == STUFF_RUN) begin
            pending = 1'b1;
            ones    = 0;
          end
        end else begin
          ones = 0;
        end
      end
      step(1'b1, b, (i == rst_at) ? 1'b0 : 1'b1, e);
    end
    e = '{v: 1'b0, b: 1'b0, e: (pending && !errored && !aborted), busy: 1'b0};
    step(1'b0, 1'b0, 1'b1, e);
    e = '{v: 1'b0, b: 1'b0, e: 1'b0, busy: 1'b0};
    step(1'b0, 1'b0, 1'b1, e);
`ifdef BIT_UNSTUFF_STATS_EN
    check_eq("drop_cnt", {16'd0, drop_cnt}, drops);
`endif
  endtask

  initial begin
    logic [63:0] rnd;
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_bit   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_bit", {31'd0, out_bit}, 32'd0);
    check_eq("rst_stuff_err", {31'd0, stuff_err}, 32'd0);
    check_eq("rst_bu_busy", {31'd0, bu_busy}, 32'd0);
`ifdef BIT_UNSTUFF_STATS_EN
    check_eq("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
`endif
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    send_packet({48'd0, 8'hA5, 8'h3C}, 16, -1);
    send_packet({48'd0, 8'hFF, 8'b1111_1101}, 16, -1);
    send_packet({45'd0, 8'hA5, 7'b111_1111, 4'b0101}, 19, -1);
    send_packet({48'd0, 8'h3C, 8'hA5}, 16, -1);
    send_packet({50'd0, 8'h5A, 6'b11_1111}, 14, -1);
    send_packet({40'd0, 8'h00, 7'b111_1110, 7'b111_1110, 2'b01}, 24, -1);
    send_packet({40'd0, 8'hFF, 6'b11_1111, 1'b0, 6'b11_1111, 3'b011}, 24, -1);
    send_packet({48'd0, 8'hA5, 8'h3C}, 16, 11);
    send_packet({48'd0, 8'hC3, 8'h5A}, 16, -1);
    for (int k = 0; k < 6; k++) begin
      rnd = {$urandom(), $urandom()};
      if (k < 3) rnd = rnd | 64'h00FF_F0FF_0FFF_F7FF;
      send_packet(rnd, 40, -1);
    end

    repeat (2) @(posedge clock);
    #1;
    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_unstuffer.md
Name: bit_unstuffer

Overview:
- Receive-side counterpart of the transmit bit stuffer.
- Takes the serial bitstream from the NRZI decoder, one bit per cycle, and removes each stuffed 0 inserted after six consecutive 1s.
- Flags bit-stuffing violations and forwards the unstuffed stream to the receive CRC checker / packet deserializer.
- The PID field is passed through without run counting, matching the transmit-side rule.

Parameters:
- PID_BITS, 8: leading bits per packet passed through without run counting; must be >= 1.
- STUFF_RUN, 6: consecutive 1s after which one stuffed 0 is expected and removed.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset_n  input  1  reset; one clock; reset is synchronous and active-low.
- rx_valid  input  1  high for every cycle of a packet, contiguous; low between packets.
- rx_bit  input  1  current received bit, qualified by rx_valid.
- out_valid  output  1  out_bit carries a payload bit this cycle (registered).
- out_bit  output  1  unstuffed bit (registered).
- stuff_err  output  1  one-cycle pulse on a stuffing violation (registered).
- bu_busy  output  1  FSM not in IDLE (combinational from state).

Behaviour:
- Reset: state=IDLE, ones_cnt=0, bit_cnt=0, out_valid=0, out_bit=0, stuff_err=0. Reset applied mid-packet aborts the packet; the remainder of that packet is not output until rx_valid goes low and returns high.
- Latency: a passed bit appears on out_valid/out_bit exactly one cycle after it is sampled. A dropped bit produces out_valid=0 in its slot; the output has no backpressure.
- ones_cnt is 3 bits. bit_cnt is $clog2(PID_BITS+1) bits. Both clear on packet start.
- IDLE:
  - rx_valid=1: pass the bit (bit 0); bit_cnt<=1.
  - Next state is PID if PID_BITS>1, else COUNT.
- PID:
  - rx_valid=1: pass the bit; bit_cnt++.
  - When the sampled bit is index PID_BITS-1: ones_cnt<=0, go to COUNT.
  - rx_valid=0: go to IDLE.
- COUNT:
  - rx_valid=1, bit=0: pass; ones_cnt<=0.
  - rx_valid=1, bit=1, ones_cnt<STUFF_RUN-1: pass; ones_cnt++.
  - rx_valid=1, bit=1, ones_cnt==STUFF_RUN-1: pass; ones_cnt<=0; go to DROP.
  - rx_valid=0: go to IDLE with no error.
- DROP:
  - rx_valid=1, bit=0: discard (out_valid=0); go to COUNT with ones_cnt=0, so the next bit starts a fresh run.
  - rx_valid=1, bit=1: discard; stuff_err pulses; go to ERROR.
  - rx_valid=0: stuff_err pulses, because the transmitter always emits the stuffed bit; go to IDLE.
- ERROR:
  - out_valid=0 for all remaining bits.
  - rx_valid=0: go to IDLE.
- A new packet requires at least one rx_valid=0 cycle; back-to-back packets without a gap are treated as one packet.
- A run of 1s ending exactly at rx_valid falling in COUNT, short of STUFF_RUN, is legal.

Optional Feature:
- Macro: BIT_UNSTUFF_STATS_EN.
- Defined:
  - Adds output drop_cnt [15:0]: the number of stuffed bits removed in the current packet.
  - Cleared on the IDLE->packet-start cycle; increments on each DROP-with-0 cycle; saturates at 16'hFFFF.
  - Holds its value after the packet ends until the next packet starts; reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package usb_rx_pkg:
  - unstuff_state_t enum {IDLE, PID, COUNT, DROP, ERROR}.
  - Constants DEFAULT_STUFF_RUN=6 and DEFAULT_PID_BITS=8, reused by the NRZI decoder and CRC checker benches.
- Sub-module bu_run_counter: the ones_cnt register with clr/inc controls and a terminal flag at STUFF_RUN-1.
- The FSM, bit_cnt and output registers stay in bit_unstuffer.

Test Plan:
- PID 8'hA5 then data 8'h3C, no run of 6: 16 out_valid pulses, out_bit stream identical to input delayed 1 cycle, stuff_err=0.
- PID 8'hFF then data 1,1,1,1,1,1,0,1: PID passes unchanged. The 0 after six data 1s gets out_valid=0 in its slot; 15 bits out; final 1 present.
- After PID, six 1s followed by a 1: stuff_err=1 for exactly one cycle one clock later; no further out_valid until rx_valid falls. The next packet decodes normally.
- After PID, six 1s then rx_valid falls: stuff_err pulses once; FSM returns to IDLE (bu_busy=0 one cycle later).
- Twelve 1s after PID with a 0 after each six: out_valid is 0 in two slots; the 7th input 1 starts a fresh run. With BIT_UNSTUFF_STATS_EN, drop_cnt=2.
- reset_n=0 for 1 cycle mid-data while rx_valid stays 1: all outputs 0 from the next edge; the rest of that packet is not output; the packet after a rx_valid gap decodes correctly.
